// File: rtl/io_guard.sv
// Z80 I/O port policing: checks each I/O cycle against a hypervisor permission mask,
// flags disallowed accesses and captures the first offending access outside trap state.
module io_guard #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        trap_state,
  input  logic        virtual_enabled,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [7:0]  cfg_data,
  output logic        io_violation,
  output logic        cap_valid,
  output logic        cap_overrun,
  output logic [7:0]  cap_port,
  output logic [7:0]  cap_data,
  output logic        cap_dir,
  output logic [15:0] perm_mask
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCheck,
    StActive,
    StWaitEnd
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] iorq_sync_q, rd_sync_q, wr_sync_q, m1_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   block_q;
  logic                   io_violation_q;
  logic                   cap_valid_q, cap_overrun_q, cap_dir_q;
  logic [7:0]             cap_port_q, cap_data_q;
  logic [15:0]            perm_mask_q;

  logic iorq_s, rd_s, wr_s, m1_s;
  logic strobe, io_start, allowed, do_capture, cap_clear;

  assign iorq_s = iorq_sync_q[SYNC_STAGES-1];
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign m1_s   = m1_sync_q[SYNC_STAGES-1];

  assign strobe     = !rd_s || !wr_s;
  // block_q keeps a cycle that straddles reset from being checked half-way through
  assign io_start   = !iorq_s && m1_s && !block_q;
  assign allowed    = perm_mask_q[addr[7:4]] || !virtual_enabled;
  assign do_capture = (state_q == StCheck) && !allowed && !trap_state;
  assign cap_clear  = cfg_we && (cfg_sel == 2'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (io_start) state_d = strobe ? StCheck : StArm;
      end
      StArm: begin
        if (iorq_s)      state_d = StIdle;
        else if (strobe) state_d = StCheck;
      end
      StCheck: begin
        state_d = allowed ? StWaitEnd : StActive;
      end
      StActive, StWaitEnd: begin
        if (iorq_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iorq_sync_q <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      m1_sync_q   <= '1;
      fill_q      <= '0;
      block_q     <= 1'b1;
      state_q     <= StIdle;
      io_violation_q <= 1'b0;
    end else begin
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], iorq_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], rd_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], wr_n};
      m1_sync_q   <= {m1_sync_q[SYNC_STAGES-2:0], m1_n};
      // fill_q marks when the synchronizer output reflects real post-reset samples
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (fill_q[SYNC_STAGES-1] && iorq_s) block_q <= 1'b0;
      state_q        <= state_d;
      io_violation_q <= (state_d == StActive);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perm_mask_q <= '0;
    end else if (cfg_we) begin
      if (cfg_sel == 2'd0) perm_mask_q[7:0]  <= cfg_data;
      if (cfg_sel == 2'd1) perm_mask_q[15:8] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid_q   <= 1'b0;
      cap_overrun_q <= 1'b0;
      cap_port_q    <= '0;
      cap_data_q    <= '0;
      cap_dir_q     <= 1'b0;
    end else if (do_capture) begin
      // A clear on the capture edge frees the slot for this capture
      if (!cap_valid_q || cap_clear) begin
        cap_valid_q   <= 1'b1;
        cap_overrun_q <= 1'b0;
        cap_port_q    <= addr;
        cap_data_q    <= !wr_s ? data_in : 8'h00;
        cap_dir_q     <= !wr_s;
      end else begin
        cap_overrun_q <= 1'b1;
      end
    end else if (cap_clear) begin
      cap_valid_q   <= 1'b0;
      cap_overrun_q <= 1'b0;
    end
  end

  assign io_violation = io_violation_q;
  assign cap_valid    = cap_valid_q;
  assign cap_overrun  = cap_overrun_q;
  assign cap_port     = cap_port_q;
  assign cap_data     = cap_data_q;
  assign cap_dir      = cap_dir_q;
  assign perm_mask    = perm_mask_q;

endmodule
